scalar_mult_ctrl: RTL and testbench

- Sequencer that computes Q = k·P with left-to-right double-and-add.
- Drives the shared point ALU one operation per cycle:
  - op 2'b00 = point add, R = A + B.
  - any nonzero op = point double, R = 2A.
  - Points are 12-bit packed projective: X=[3:0], Y=[7:4], Z=[11:8].
- The ALU is combinational and instantiated beside this block. This controller owns the operand registers, the op select and the result writeback.

---
 rtl/scalar_mult_ctrl.sv | 131 +++++++++++++
 tb/tb_scalar_mult_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P.
// Owns the Q, P and scalar registers and drives a combinational point ALU
// that sits beside this block: A is always Q, B is always the latched P.
//
// state | meaning
// IDLE  | waiting for start; Q holds the last result
// SCAN  | skipping leading zero bits of k, loads Q=P at the MSB
// DBL   | Q <= 2Q for the current bit
// ADD   | Q <= Q + P for a set bit
// DONE  | one-cycle completion pulse
module scalar_mult_ctrl #(
  parameter int K_WIDTH = 4,
  parameter int PT_WIDTH = 12,
  parameter logic [PT_WIDTH-1:0] INF_PT = 12'h010
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [K_WIDTH-1:0]  k,
  input  logic [PT_WIDTH-1:0] p_in,
  input  logic [PT_WIDTH-1:0] alu_r,
  output logic [1:0]          alu_op,
  output logic [PT_WIDTH-1:0] alu_a,
  output logic [PT_WIDTH-1:0] alu_b,
  output logic                busy,
  output logic                done,
  output logic [PT_WIDTH-1:0] q_out
);

  localparam int IW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(K_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    DBL  = 3'd2,
    ADD  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [K_WIDTH-1:0]  k_reg, k_nxt;
  logic [PT_WIDTH-1:0] p_reg, p_nxt;
  logic [PT_WIDTH-1:0] q_reg, q_nxt;
  logic [IW-1:0]       idx, idx_nxt;

  assign alu_a  = q_reg;
  assign alu_b  = p_reg;
  assign q_out  = q_reg;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign alu_op = (state == DBL) ? 2'b01 : 2'b00;

  // Register update; synchronous reset returns everything to IDLE defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k_reg <= '0;
      p_reg <= '0;
      q_reg <= '0;
      idx   <= I_TOP;
    end else begin
      state <= state_nxt;
      k_reg <= k_nxt;
      p_reg <= p_nxt;
      q_reg <= q_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state and datapath selection for one scalar bit per cycle.
  always_comb begin
    state_nxt = state;
    k_nxt     = k_reg;
    p_nxt     = p_reg;
    q_nxt     = q_reg;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          k_nxt     = k;
          p_nxt     = p_in;
          idx_nxt   = I_TOP;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (k_reg == '0) begin
          q_nxt     = INF_PT;
          state_nxt = DONE;
        end else if (k_reg[idx]) begin
          q_nxt = p_reg;
          if (idx == '0) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx - 1'b1;
            state_nxt = DBL;
          end
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
      DBL: begin
        q_nxt = alu_r;
        if (k_reg[idx]) begin
          state_nxt = ADD;
        end else if (idx == '0) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
      ADD: begin
        q_nxt = alu_r;
        if (idx == '0) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx - 1'b1;
          state_nxt = DBL;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl with an integer ALU stub (Q = k*P mod 4096).
module tb_scalar_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  k;
  logic [11:0] p_in;
  logic [11:0] alu_r;
  logic [1:0]  alu_op;
  logic [11:0] alu_a;
  logic [11:0] alu_b;
  logic        busy;
  logic        done;
  logic [11:0] q_out;

  int errors = 0;
  int checks = 0;

  scalar_mult_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .k(k), .p_in(p_in),
    .alu_r(alu_r), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .busy(busy), .done(done), .q_out(q_out)
  );

  // integer ALU stub: add or double, wrapping at 12 bits
  assign alu_r = (alu_op == 2'b00) ? 12'(alu_a + alu_b) : 12'(alu_a << 1);

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // reference: result value
  function automatic int ref_q(input int kk, input int pp);
    if (kk == 0) return 'h010;
    return (kk * pp) % 4096;
  endfunction

  // reference: cycle (relative to accepting edge = T0) on which done is high
  function automatic int ref_done_cyc(input int kk);
    int m, pop;
    if (kk == 0) return 2;
    m = 0;
    for (int b = 0; b < 4; b++) if ((kk >> b) & 1) m = b;
    pop = 0;
    for (int b = 0; b < m; b++) pop += (kk >> b) & 1;
    return (3 - m) + 1 + m + pop + 1;
  endfunction

  function automatic int ref_dbls(input int kk);
    for (int b = 3; b >= 0; b--) if ((kk >> b) & 1) return b;
    return 0;
  endfunction

  // one full operation from an idle DUT; noisy toggles start/k/p_in while busy
  task automatic run_op(input int kk, input int pp, input bit noisy);
    int cyc, dbl;
    logic [11:0] q_seen;
    @(negedge clk);
    start = 1'b1; k = 4'(kk); p_in = 12'(pp);
    @(negedge clk);
    cyc = 1; dbl = 0;
    check_eq("busy_t1", int'(busy), 1);
    while (!done && cyc < 40) begin
      if (alu_op == 2'b01) dbl++;
      check_eq("busy_run", int'(busy), 1);
      start = noisy ? 1'($urandom) : 1'b0;
      if (noisy) begin
        k = 4'($urandom);
        p_in = 12'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq("done_cycle", cyc, ref_done_cyc(kk));
    check_eq("q_at_done", int'(q_out), ref_q(kk, pp));
    check_eq("dbl_count", dbl, ref_dbls(kk));
    check_eq("busy_done", int'(busy), 1);
    q_seen = q_out;
    @(negedge clk);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_done", int'(done), 0);
    check_eq("q_hold", int'(q_out), int'(q_seen));
  endtask

  initial begin
    int d1, d2, c;
    rst = 1'b1; start = 1'b0; k = '0; p_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_q", int'(q_out), 0);
    check_eq("rst_op", int'(alu_op), 0);
    rst = 1'b0;

    run_op(4'b1011, 'h003, 1'b0);
    run_op(4'b0001, 'h0A5, 1'b0);
    run_op(0, 'h123, 1'b0);
    run_op(4'b1111, 'h001, 1'b1);

    // reset mid-operation
    @(negedge clk);
    start = 1'b1; k = 4'b1011; p_in = 12'h003;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_done", int'(done), 0);
    check_eq("mid_rst_q", int'(q_out), 0);
    check_eq("mid_rst_op", int'(alu_op), 0);
    rst = 1'b0;
    run_op(2, 'h005, 1'b0);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; k = 4'd3; p_in = 12'h007;
    d1 = -1; d2 = -1; c = 0;
    while (d2 < 0 && c < 40) begin
      @(negedge clk);
      c++;
      if (d1 >= 0 && c == d1 + 1) begin
        check_eq("b2b_idle_busy", int'(busy), 0);
        check_eq("b2b_idle_q", int'(q_out), 21);
      end
      if (done) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
    end
    start = 1'b0;
    check_eq("b2b_second_done", int'(d2 >= 0), 1);
    check_eq("b2b_spacing", d2 - d1, ref_done_cyc(3) + 1);
    check_eq("b2b_q", int'(q_out), 21);
    repeat (2) @(negedge clk);

    // randomized operations
    for (int n = 0; n < 20; n++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
